regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback requesters: requester 0 (ALU result) and requester 1 (load/memory result).
- Arbitrates round-robin with a valid/ready handshake per requester.
- Registers the winning write into a one-entry output stage that drives the register file write port, and exposes that stage for bypass logic.
- Keeps a saturating contention counter for performance monitoring.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, write data width.
- ZERO_RO, 1, when 1, writes to address 0 are accepted but never reach the register file.
- CNT_W, 16, contention counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- stall  input  1  freeze: no grants issued while high.
- req0_valid  input  1  requester 0 has a write.
- req0_addr  input  ADDR_W  requester 0 destination register.
- req0_data  input  DATA_W  requester 0 write data.
- req0_ready  output  1  requester 0 write accepted this cycle.
- req1_valid  input  1  requester 1 has a write.
- req1_addr  input  ADDR_W  requester 1 destination register.
- req1_data  input  DATA_W  requester 1 write data.
- req1_ready  output  1  requester 1 write accepted this cycle.
- write_enable  output  1  register file write enable (registered).
- write_addr  output  ADDR_W  register file write address (registered).
- data_in  output  DATA_W  register file write data (registered).
- pend_valid  output  1  output stage holds a write (bypass qualifier).
- pend_src  output  1  requester index of the write in the output stage.
- contention_cnt  output  CNT_W  count of cycles with both requests valid and stall low, saturating.

Behaviour:
- Reset (async, rst=1) forces:
  - write_enable=0, write_addr=0, data_in=0.
  - pend_valid=0, pend_src=0.
  - contention_cnt=0.
  - rr_ptr=0 (requester 0 preferred).
- Asserting rst mid-operation discards any write in the output stage; no write_enable pulse follows.
- Grant logic is combinational and evaluated each cycle:
  - If stall=1: both ready outputs are 0.
  - Else, only one requester valid: that requester is granted.
  - Else, both valid: the requester selected by rr_ptr is granted.
  - Never grant both in the same cycle.
- reqN_ready = granted to N. A transfer occurs when valid and ready are both high.
- Requesters must hold addr and data stable while valid is high and ready is low.
- rr_ptr update on the clock edge after a transfer from requester i: rr_ptr <= ~i. rr_ptr is unchanged in cycles with no transfer.
- Output stage is updated every clock edge:
  - pend_valid <= transfer occurred.
  - pend_src <= granted index.
  - write_addr and data_in <= granted addr and data when a transfer occurred; otherwise they hold their previous values.
  - write_enable <= transfer occurred AND NOT (ZERO_RO=1 AND granted addr=0).
- Latency: the register file write happens exactly 1 cycle after the transfer. Throughput is 1 write per cycle.
- Address 0 with ZERO_RO=1:
  - Handshake completes and pend_valid=1, so the bypass logic sees it.
  - write_enable stays 0.
- The output stage is a pipeline register, not a buffer. The register file always accepts a write, so no back-pressure comes from downstream.
- stall=1 does not cancel a write already in the output stage; that write completes on the next edge.
- contention_cnt increments when req0_valid=1, req1_valid=1 and stall=0. It saturates at 2^CNT_W-1 and never wraps.
- A requester that deasserts valid without a transfer loses nothing; rr_ptr is not affected.

Test Plan:
- Reset then single write: req0 {addr=5, data=0xDEADBEEF} valid for 1 cycle -> req0_ready=1 that cycle; next cycle write_enable=1, write_addr=5, data_in=0xDEADBEEF, pend_src=0; following cycle write_enable=0.
- Sustained contention: both valid for 4 cycles (req0 addr=1..4, req1 addr=11..14, advancing on each transfer) -> grants alternate 0,1,0,1; write_addr sequence 1,11,2,12; contention_cnt=4.
- Stall: both valid, stall=1 for 3 cycles -> both ready=0, write_enable=0, contention_cnt unchanged; after stall drops, requester 0 is granted first (rr_ptr still 0).
- Zero register: req1 addr=0, data=0x1234, ZERO_RO=1 -> req1_ready=1; next cycle pend_valid=1, pend_src=1, write_enable=0.
- Saturation: CNT_W=3, both valid for 10 cycles -> contention_cnt reads 7 from cycle 7 onward.
- Async reset mid-write: assert rst between the transfer edge and the following edge -> write_enable, pend_valid and contention_cnt drop to 0 immediately; after release, requester 0 is preferred.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// and load writeback paths, with a one-entry registered output stage.
module regfile_write_arbiter #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ZERO_RO = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] data_in,
    output logic              pend_valid,
    output logic              pend_src,
    output logic [CNT_W-1:0]  contention_cnt
);

    logic              rr_ptr;
    logic              gnt0;
    logic              gnt1;
    logic              xfer;
    logic              gnt_idx;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic              gnt_we;
    logic              contend;

    // Grant selection: a lone requester wins, otherwise rr_ptr breaks the tie.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        gnt_idx  = 1'b0;
        gnt_addr = req0_addr;
        gnt_data = req0_data;
        gnt_we   = 1'b0;
        contend  = 1'b0;
        if (!stall) begin
            contend = req0_valid && req1_valid;
            gnt0    = req0_valid && (!req1_valid || !rr_ptr);
            gnt1    = req1_valid && (!req0_valid ||  rr_ptr);
        end
        if (gnt1) begin
            gnt_idx  = 1'b1;
            gnt_addr = req1_addr;
            gnt_data = req1_data;
        end
        xfer   = gnt0 || gnt1;
        // Writes to r0 still complete the handshake but never reach the array.
        gnt_we = xfer && !((ZERO_RO != 0) && (gnt_addr == '0));
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Output stage, round-robin pointer and contention counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr         <= 1'b0;
            write_enable   <= 1'b0;
            write_addr     <= '0;
            data_in        <= '0;
            pend_valid     <= 1'b0;
            pend_src       <= 1'b0;
            contention_cnt <= '0;
        end else begin
            pend_valid   <= xfer;
            pend_src     <= gnt_idx;
            write_enable <= gnt_we;
            if (xfer) begin
                rr_ptr     <= ~gnt_idx;
                write_addr <= gnt_addr;
                data_in    <= gnt_data;
            end
            if (contend && (contention_cnt != '1)) begin
                contention_cnt <= contention_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter; a second instance with a 3-bit
// counter shares the stimulus to exercise saturation.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_addr = '0;
    logic [31:0] req0_data = '0;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_addr = '0;
    logic [31:0] req1_data = '0;

    logic        req0_ready, req1_ready, write_enable, pend_valid, pend_src;
    logic [4:0]  write_addr;
    logic [31:0] data_in;
    logic [15:0] contention_cnt;

    logic        s_req0_ready, s_req1_ready, s_write_enable, s_pend_valid, s_pend_src;
    logic [4:0]  s_write_addr;
    logic [31:0] s_data_in;
    logic [2:0]  s_contention_cnt;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .write_enable(write_enable), .write_addr(write_addr), .data_in(data_in),
        .pend_valid(pend_valid), .pend_src(pend_src), .contention_cnt(contention_cnt)
    );

    regfile_write_arbiter #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(s_req1_ready),
        .write_enable(s_write_enable), .write_addr(s_write_addr), .data_in(s_data_in),
        .pend_valid(s_pend_valid), .pend_src(s_pend_src), .contention_cnt(s_contention_cnt)
    );

    typedef struct {
        logic        pv;
        logic        src;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        int unsigned cnt;
        int unsigned cnt3;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        m_rr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int unsigned m_cnt, m_cnt3;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0; m_cnt3 = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive, check grants, push the expected output stage, pop and compare after the edge.
    task automatic cyc(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic st, output logic t0, output logic t1);
        logic g0, g1;
        exp_t e;
        stall = st;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        g0 = !st && v0 && (!v1 || !m_rr);
        g1 = !st && v1 && (!v0 || m_rr);
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        check("sat_req0_ready", s_req0_ready, g0);
        if (!st && v0 && v1) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt3 < 7) m_cnt3++;
        end
        if (g0) begin m_addr = a0; m_data = d0; m_rr = 1'b1; end
        if (g1) begin m_addr = a1; m_data = d1; m_rr = 1'b0; end
        e.pv = g0 || g1;
        e.src = g1;
        e.we = (g0 || g1) && (m_addr != 5'd0);
        e.addr = m_addr;
        e.data = m_data;
        e.cnt = m_cnt;
        e.cnt3 = m_cnt3;
        sb.push_back(e);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("pend_valid", pend_valid, e.pv);
            check("pend_src", pend_src, e.src);
            check("write_enable", write_enable, e.we);
            check("write_addr", write_addr, e.addr);
            check("data_in", data_in, e.data);
            check("contention_cnt", contention_cnt, e.cnt);
            check("sat_contention_cnt", s_contention_cnt, e.cnt3);
        end
        t0 = g0; t1 = g1;
    endtask

    initial begin
        logic t0, t1;
        logic [4:0] a0, a1;
        logic [4:0] exp_seq[4];
        exp_seq[0] = 5'd1; exp_seq[1] = 5'd11; exp_seq[2] = 5'd2; exp_seq[3] = 5'd12;

        // Reset state
        #1;
        check("rst_write_enable", write_enable, 0);
        check("rst_write_addr", write_addr, 0);
        check("rst_data_in", data_in, 0);
        check("rst_pend_valid", pend_valid, 0);
        check("rst_pend_src", pend_src, 0);
        check("rst_contention_cnt", contention_cnt, 0);
        do_reset();

        // Single write from requester 0
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, t0, t1);
        check("single_ready0", t0, 1);
        check("single_we", write_enable, 1);
        check("single_addr", write_addr, 5);
        check("single_data", data_in, 32'hDEADBEEF);
        check("single_src", pend_src, 0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, t0, t1);
        check("single_we_drop", write_enable, 0);

        // Sustained contention alternates grants
        do_reset();
        a0 = 5'd1; a1 = 5'd11;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, a0, 32'h100 + 32'(a0), 1'b1, a1, 32'h200 + 32'(a1), 1'b0, t0, t1);
            check("rr_grant_src", pend_src, (i % 2));
            check("rr_seq_addr", write_addr, exp_seq[i]);
            if (t0) a0++;
            if (t1) a1++;
        end
        check("rr_cnt4", contention_cnt, 4);

        // Stall freezes grants and the counter
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, t0, t1);
            check("stall_no_grant", {t0, t1}, 0);
            check("stall_we", write_enable, 0);
        end
        check("stall_cnt", contention_cnt, 0);
        cyc(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, t0, t1);
        check("post_stall_req0_first", t0, 1);

        // Zero register write is accepted but suppressed
        do_reset();
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, t0, t1);
        check("zero_ready1", t1, 1);
        check("zero_pend_valid", pend_valid, 1);
        check("zero_pend_src", pend_src, 1);
        check("zero_we", write_enable, 0);

        // Saturation on the 3-bit counter instance
        do_reset();
        a0 = 5'd1; a1 = 5'd16;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, a0, 32'(i), 1'b1, a1, 32'(i) << 8, 1'b0, t0, t1);
            if (i >= 7) check("sat_cnt7", s_contention_cnt, 7);
            if (t0) a0++;
            if (t1) a1++;
        end
        check("sat_wide_cnt", contention_cnt, 10);

        // Async reset between the transfer edge and the write edge
        do_reset();
        cyc(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b0, t0, t1);
        check("mid_pre_pv", pend_valid, 1);
        check("mid_pre_cnt", contention_cnt, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_we", write_enable, 0);
        check("mid_rst_pv", pend_valid, 0);
        check("mid_rst_cnt", contention_cnt, 0);
        @(posedge clk); #1;
        check("mid_rst_hold_we", write_enable, 0);
        rst = 1'b0;
        model_reset();
        cyc(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b0, t0, t1);
        check("mid_rst_req0_pref", t0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
